// File: rtl/reg_file_scoreboard.sv
// Parametrised register file with two write ports, PC-relative top register and a pending-write
// scoreboard. Define RF_BYPASS_EN to enable write-through read forwarding.
`timescale 1ns/1ps
module reg_file_scoreboard #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned NUM_RD    = 3,
  parameter int unsigned PC_OFFSET = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rd_hazard,
  input  logic [DATA_W-1:0]          pc,
  input  logic                       we3,
  input  logic [ADDR_W-1:0]          wa3,
  input  logic [DATA_W-1:0]          wd3,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_a0,
  input  logic [ADDR_W-1:0]          iss_a1,
  input  logic                       iss_dual,
  output logic                       iss_stall,
  output logic [(2**ADDR_W)-1:0]     busy,
  output logic [ADDR_W:0]            pending
);

  localparam int unsigned NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(NREG - 1);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d, clr, set;
  logic [ADDR_W:0]   pending_q, pending_d;
  logic [DATA_W-1:0] pc_rel;
  logic              blocked0, blocked1;

  assign pc_rel = pc + DATA_W'(PC_OFFSET);

  // Register writes; W3 is applied last so it wins on an address collision.
  always_comb begin
    regs_d = regs_q;
    if (we1 && wa1 != PcAddr) regs_d[wa1] = wd1;
    if (we3 && wa3 != PcAddr) regs_d[wa3] = wd3;
  end

  always_comb begin
    clr = '0;
    if (we1) clr[wa1] = 1'b1;
    if (we3) clr[wa3] = 1'b1;
  end

  // A destination is only blocking if no write retires it on this same edge.
  assign blocked0  = busy_q[iss_a0] & ~clr[iss_a0];
  assign blocked1  = busy_q[iss_a1] & ~clr[iss_a1];
  assign iss_stall = iss_valid & (blocked0 | (iss_dual & (blocked1 | (iss_a0 == iss_a1))));

  always_comb begin
    set = '0;
    if (iss_valid && !iss_stall) begin
      set[iss_a0] = 1'b1;
      if (iss_dual) set[iss_a1] = 1'b1;
    end
    set[NREG-1] = 1'b0;
    // Set after clear so a same-cycle reservation survives the retiring write.
    busy_d = (busy_q & ~clr) | set;
  end

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < int'(NREG); i++) pending_d = pending_d + (ADDR_W+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign busy    = busy_q;
  assign pending = pending_q;

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              haz;

    assign addr = ra[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs_q[addr];
      haz  = busy_q[addr];
`ifdef RF_BYPASS_EN
      if (we3 && wa3 == addr)      data = wd3;
      else if (we1 && wa1 == addr) data = wd1;
      if ((we3 && wa3 == addr) || (we1 && wa1 == addr)) haz = 1'b0;
`endif
      if (addr == PcAddr) begin
        data = pc_rel;
        haz  = 1'b0;
      end
    end

    assign rd[k*DATA_W +: DATA_W] = data;
    assign rd_hazard[k]           = haz;
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed self-checking bench for reg_file_scoreboard (default parameters).
`timescale 1ns/1ps
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] ra;
  logic [95:0] rd;
  logic [2:0]  rd_hazard;
  logic [31:0] pc;
  logic        we3, we1;
  logic [3:0]  wa3, wa1;
  logic [31:0] wd3, wd1;
  logic        iss_valid, iss_dual;
  logic [3:0]  iss_a0, iss_a1;
  logic        iss_stall;
  logic [15:0] busy;
  logic [4:0]  pending;

  int total = 0;
  int bad   = 0;

`ifdef RF_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  reg_file_scoreboard dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rd_hazard(rd_hazard), .pc(pc),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_a0(iss_a0), .iss_a1(iss_a1), .iss_dual(iss_dual),
    .iss_stall(iss_stall), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pack(input logic [3:0] a0, input logic [3:0] a1,
                                       input logic [3:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we3 = 0; we1 = 0; wa3 = 0; wa1 = 0; wd3 = 0; wd1 = 0;
    iss_valid = 0; iss_dual = 0; iss_a0 = 0; iss_a1 = 0;
  endtask

  task automatic test_reset;
    reset = 1; idle(); pc = 32'd128; ra = pack(4'd1, 4'd2, 4'd15);
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 16'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    total++; if (pending !== 5'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    total++; if (rd[31:0] !== 32'd0) begin bad++; $display("FAIL reset_rd0 got=%0d exp=0", rd[31:0]); end
    total++; if (rd[95:64] !== 32'd136) begin bad++; $display("FAIL reset_r15 got=%0d exp=136", rd[95:64]); end
    reset = 0;
    tick();
  endtask

  task automatic test_write_read;
    we3 = 1; wa3 = 4'd1; wd3 = 32'd15; we1 = 1; wa1 = 4'd11; wd1 = 32'd32;
    tick();
    idle(); pc = 32'd128; ra = pack(4'd1, 4'd11, 4'd15);
    #1;
    total++; if (rd !== {32'd136, 32'd32, 32'd15}) begin bad++; $display("FAIL write_read got=%h exp=%h", rd, {32'd136, 32'd32, 32'd15}); end
    total++; if (rd_hazard !== 3'b000) begin bad++; $display("FAIL write_read_haz got=%b exp=000", rd_hazard); end
  endtask

  task automatic test_same_addr;
    we3 = 1; wa3 = 4'd2; wd3 = 32'hAAAA; we1 = 1; wa1 = 4'd2; wd1 = 32'h5555;
    tick();
    idle(); we3 = 1; wa3 = 4'd15; wd3 = 32'hFFFF_FFFF;
    tick();
    idle(); pc = 32'd200; ra = pack(4'd2, 4'd15, 4'd0);
    #1;
    total++; if (rd[31:0] !== 32'hAAAA) begin bad++; $display("FAIL w3_priority got=%h exp=0000aaaa", rd[31:0]); end
    total++; if (rd[63:32] !== 32'd208) begin bad++; $display("FAIL r15_write_ignored got=%0d exp=208", rd[63:32]); end
  endtask

  task automatic test_issue;
    iss_valid = 1; iss_dual = 1; iss_a0 = 4'd4; iss_a1 = 4'd5;
    #1;
    total++; if (iss_stall !== 1'b0) begin bad++; $display("FAIL dual_issue_stall got=%b exp=0", iss_stall); end
    tick();
    idle(); ra = pack(4'd4, 4'd1, 4'd5);
    #1;
    total++; if (busy !== 16'h0030) begin bad++; $display("FAIL dual_issue_busy got=%h exp=0030", busy); end
    total++; if (pending !== 5'd2) begin bad++; $display("FAIL dual_issue_pending got=%0d exp=2", pending); end
    total++; if (rd_hazard !== 3'b101) begin bad++; $display("FAIL dual_issue_haz got=%b exp=101", rd_hazard); end
    iss_valid = 1; iss_a0 = 4'd5;
    #1;
    total++; if (iss_stall !== 1'b1) begin bad++; $display("FAIL reissue_stall got=%b exp=1", iss_stall); end
    tick();
    idle();
    total++; if (pending !== 5'd2) begin bad++; $display("FAIL stalled_pending got=%0d exp=2", pending); end
    iss_valid = 1; iss_dual = 1; iss_a0 = 4'd8; iss_a1 = 4'd8;
    #1;
    total++; if (iss_stall !== 1'b1) begin bad++; $display("FAIL dual_same_stall got=%b exp=1", iss_stall); end
    tick();
    idle();
    total++; if (busy !== 16'h0030) begin bad++; $display("FAIL dual_same_nostate got=%h exp=0030", busy); end
  endtask

  task automatic test_write_issue_same;
    we3 = 1; wa3 = 4'd4; wd3 = 32'd7; iss_valid = 1; iss_a0 = 4'd4;
    #1;
    total++; if (iss_stall !== 1'b0) begin bad++; $display("FAIL clear_reissue_stall got=%b exp=0", iss_stall); end
    tick();
    idle(); ra = pack(4'd4, 4'd5, 4'd0);
    #1;
    total++; if (rd[31:0] !== 32'd7) begin bad++; $display("FAIL clear_reissue_data got=%0d exp=7", rd[31:0]); end
    total++; if (busy !== 16'h0030) begin bad++; $display("FAIL clear_reissue_busy got=%h exp=0030", busy); end
    total++; if (pending !== 5'd2) begin bad++; $display("FAIL clear_reissue_pending got=%0d exp=2", pending); end
    we1 = 1; wa1 = 4'd5; wd1 = 32'd55;
    tick();
    idle();
    #1;
    total++; if (busy !== 16'h0010) begin bad++; $display("FAIL w1_clear_busy got=%h exp=0010", busy); end
    total++; if (pending !== 5'd1) begin bad++; $display("FAIL w1_clear_pending got=%0d exp=1", pending); end
    total++; if (rd[63:32] !== 32'd55) begin bad++; $display("FAIL w1_clear_data got=%0d exp=55", rd[63:32]); end
  endtask

  task automatic test_bypass;
    logic [31:0] exp0, exp1;
    logic [2:0]  exph;
    exp0 = Bypass ? 32'd99 : 32'd0;
    exp1 = Bypass ? 32'd44 : 32'd7;
    exph = Bypass ? 3'b000 : 3'b010;
    ra = pack(4'd6, 4'd4, 4'd3);
    we3 = 1; wa3 = 4'd6; wd3 = 32'd99; we1 = 1; wa1 = 4'd4; wd1 = 32'd44;
    #1;
    total++; if (rd[31:0] !== exp0) begin bad++; $display("FAIL bypass_rd6 got=%0d exp=%0d", rd[31:0], exp0); end
    total++; if (rd[63:32] !== exp1) begin bad++; $display("FAIL bypass_rd4 got=%0d exp=%0d", rd[63:32], exp1); end
    total++; if (rd_hazard !== exph) begin bad++; $display("FAIL bypass_haz got=%b exp=%b", rd_hazard, exph); end
    tick();
    idle();
    #1;
    total++; if (rd[63:0] !== {32'd44, 32'd99}) begin bad++; $display("FAIL post_write_rd got=%h exp=%h", rd[63:0], {32'd44, 32'd99}); end
    total++; if (pending !== 5'd0) begin bad++; $display("FAIL post_write_pending got=%0d exp=0", pending); end
  endtask

  task automatic test_reset_mid;
    iss_valid = 1; iss_a0 = 4'd7;
    tick();
    idle(); ra = pack(4'd1, 4'd6, 4'd4);
    total++; if (busy !== 16'h0080) begin bad++; $display("FAIL reserve_r7 got=%h exp=0080", busy); end
    #2 reset = 1;
    #0.1;
    total++; if (busy !== 16'h0) begin bad++; $display("FAIL async_busy got=%h exp=0", busy); end
    reset = 0;
    #0.1;
    total++; if (pending !== 5'd0) begin bad++; $display("FAIL async_pending got=%0d exp=0", pending); end
    total++; if (rd[95:0] !== 96'd0) begin bad++; $display("FAIL async_rd got=%h exp=0", rd); end
    we3 = 1; wa3 = 4'd7; wd3 = 32'd5;
    tick();
    idle(); ra = pack(4'd7, 4'd0, 4'd0);
    #1;
    total++; if (busy !== 16'h0) begin bad++; $display("FAIL late_write_busy got=%h exp=0", busy); end
    total++; if (rd[31:0] !== 32'd5) begin bad++; $display("FAIL late_write_data got=%0d exp=5", rd[31:0]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_addr();
    test_issue();
    test_write_issue_same();
    test_bypass();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Parametrised successor to the datapath register file. Adds configurable data width, register count and read-port count.
- Keeps the two write ports (W3 primary result, W1 secondary result / base writeback) and the PC-relative read of the top register.
- Adds a pending-write scoreboard so multi-cycle units (long multiply, loads) can reserve destinations.
- The scoreboard flags read hazards to the control unit.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 4, register address width; NREG = 2**ADDR_W registers
NUM_RD, 3, number of combinational read ports
PC_OFFSET, 8, value added to pc when the PC register is read

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all registers and the scoreboard
ra  in  NUM_RD*ADDR_W  read addresses, port k = bits [k*ADDR_W +: ADDR_W]
rd  out  NUM_RD*DATA_W  read data, same packing as ra
rd_hazard  out  NUM_RD  port k reads a register whose busy bit is set
pc  in  DATA_W  current program counter
we3, wa3, wd3  in  1/ADDR_W/DATA_W  write port 3
we1, wa1, wd1  in  1/ADDR_W/DATA_W  write port 1
iss_valid  in  1  reserve destination(s) this cycle
iss_a0, iss_a1  in  ADDR_W  destinations to reserve
iss_dual  in  1  also reserve iss_a1
iss_stall  out  1  reservation refused
busy  out  NREG  scoreboard bitmap, registered
pending  out  ADDR_W+1  number of busy bits set

Behaviour:
- Reset (async): all registers = 0, busy = 0, pending = 0. rd reflects the cleared registers immediately.
- Reads are combinational.
- Read of address NREG-1 (r15) returns pc + PC_OFFSET, modulo 2**DATA_W. r15 is never hazarded.
- Writes occur on the rising edge. Writes to r15 are ignored; the PC is owned by the fetch stage.
- If we3 and we1 target the same address, wd3 wins.
- Scoreboard, iss_stall:
  - Combinational. Asserted when iss_valid and any requested destination (iss_a0, plus iss_a1 if iss_dual) is already busy and is not being cleared by a write this cycle.
  - Also asserted when iss_dual and iss_a0 == iss_a1.
  - Stalled issues change no state.
- Scoreboard, accepted issue (iss_valid and !iss_stall): busy bits of the destinations are set on the next edge. Reservation of r15 is ignored.
- Scoreboard, clearing: a write on either port to a busy register clears its busy bit on the same edge that stores the data.
- Simultaneous write and issue to the same register in one cycle: the register takes the data, and busy ends up SET (the issue wins over the clear).
- Writing a non-busy register: the data is stored and busy stays 0.
- pending: registered population count of busy, updated on the same edge. Range 0..NREG-1.
- rd_hazard[k] = busy[ra_k] & (ra_k != NREG-1), taken from the registered busy.
- Reset asserted mid-operation drops all reservations. In-flight writes arriving after reset are stored normally and leave busy at 0.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - Write-through forwarding. A read of an address being written this cycle returns the write data, with W3 priority over W1.
  - rd_hazard for that port is suppressed if the write clears the reservation.
- Undefined:
  - Reads return the stored value until after the edge.
  - rd_hazard follows busy only.

Test Plan:
- Reset, then write r1=15 via W3 and r11=32 via W1 in the same cycle; next cycle read ra={r1,r11,r15} with pc=128 -> rd = {15, 32, 136}, no hazards.
- Same-cycle we3 r2=0xAAAA and we1 r2=0x5555 -> r2 = 0xAAAA; a write to r15 of 0xFFFF_FFFF leaves the r15 read at pc+8.
- Dual issue r4,r5 -> busy[4]=busy[5]=1, pending=2, rd_hazard on a port reading r4. Then issue r5 again -> iss_stall=1 and pending stays 2.
- W3 writes r4=7 while a new issue of r4 occurs in the same cycle -> r4=7, busy[4]=1, pending unchanged. Then W1 writes r5 -> busy[5]=0, pending=1.
- With RF_BYPASS_EN, write r6=99 while reading r6 -> rd=99 in the same cycle. Without the macro -> old value, then 99 on the next cycle.
- Reserve r7, then pulse reset for 100 ps away from a clock edge -> busy=0, pending=0 and all reads 0 immediately. A later write to r7 leaves busy[7]=0.
